uart_tx_framer: RTL and testbench
=================================

// Module: uart_tx_framer
// PURPOSE
//  Upstream control stage of the UART transmit path: accepts a byte over a valid/ready
//  handshake and builds a 12-bit frame (start, 8 data LSB-first, parity, 2 stop bits).
//  Drives the 12-bit TX shift register's load/en/parallel-in/fill inputs at the baud rate.
//  Reports busy/done to the core. Runs on the rising edge; the shift register samples
//  its load/en inputs on the following falling edge.
// PARAMETERS
//  CLK_DIV     434  clk cycles per bit period (>=2); 434 = 50 MHz / 115200
//  PARITY_ODD  0    0: even parity bit, 1: odd parity bit
// PORTS
//  clk       in   1   system clock; all state updates on posedge
//  reset     in   1   asynchronous, active-low reset (asserted when 0)
//  tx_data   in   8   byte to send, sampled when tx_valid && tx_ready
//  tx_valid  in   1   byte available
//  tx_ready  out  1   framer idle, can accept a byte
//  sr_load   out  1   1-cycle pulse: shift register loads sr_frame
//  sr_en     out  1   1-cycle pulse: shift register shifts one bit onto the line
//  sr_frame  out  12  frame to be loaded into the shift register
//  sr_fill   out  1   serial fill bit into shift register MSB; tied to 1 (idle level)
//  busy      out  1   frame in progress (~tx_ready)
//  done      out  1   1-cycle pulse when the last stop bit has been held a full bit period
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE, tx_ready=1, busy=0, sr_load=0, sr_en=0, done=0,
//   sr_frame=12'h000, baud counter=0, bit counter=0. sr_fill is always 1.
//  Frame: [0]=0, [8:1]=tx_data, [9]=^tx_data ^ PARITY_ODD, [11:10]=2'b11.
//  FSM states: IDLE, LOAD, SHIFT, HOLD.
//   IDLE : tx_ready=1. On tx_valid, register sr_frame and go to LOAD. tx_data is ignored
//          without tx_valid.
//   LOAD : sr_load=1 for exactly this cycle; clear baud counter and bit counter; go to SHIFT.
//   SHIFT: baud counter counts 0..CLK_DIV-1 and wraps. On terminal count, sr_en=1 for one
//          cycle and the bit counter increments. After the 12th sr_en pulse, go to HOLD.
//   HOLD : wait one full bit period (CLK_DIV cycles) so stop bit 2 has full width. Then
//          done=1 for one cycle and go to IDLE.
//  Timing: handshake accepted at edge T -> sr_load high in cycle T+1.
//   sr_en pulse k (k=1..12) is high in cycle T+1+k*CLK_DIV.
//   done is high in cycle T+1+13*CLK_DIV, and tx_ready=1 from the next cycle.
//   The shift register holds the line at 1 between load and the first en. This gives one
//   idle bit time before the start bit.
//  tx_valid while busy: ignored (tx_ready=0); the byte must be held until accepted.
//  Back-to-back: tx_valid held high gets accepted the cycle after done returns to IDLE.
//  sr_load and sr_en are never high in the same cycle. sr_frame is stable from LOAD until
//   the next accepted byte.
//  Reset asserted mid-frame: immediately abort to the reset values; no done pulse. The
//   shift register is reset by the same signal, so the line returns to 1.
//  Widths: baud counter is $clog2(CLK_DIV) bits; bit counter is 4 bits and saturates
//   logically at 12.
// STRUCTURE
//  uart_pkg: localparam FRAME_BITS=12, STOP_BITS=2, the tx_state_t enum
//   {IDLE,LOAD,SHIFT,HOLD}, and function build_frame(data, parity_odd) -> [11:0].
//  Sub-module uart_baud_gen (CLK_DIV): inputs clk, reset, clear, run; output 1-cycle tick.
//   It is reused later by the receive path.
// TESTING (sim with CLK_DIV=4, PARITY_ODD=0 unless stated)
//  1. Hold reset=0 for 3 cycles with tx_valid=1 -> tx_ready=1, sr_load=sr_en=done=0.
//     Release -> byte accepted on the first edge.
//  2. Send 0xA5 -> sr_frame=12'hD4A and one sr_load pulse. Exactly 12 sr_en pulses 4
//     cycles apart, first at T+5. done at T+53. A shift-register model emits line
//     1,0,1,0,1,0,0,1,0,1,0,1,1.
//  3. Send 0x07 -> sr_frame=12'hE0E (parity 1). With PARITY_ODD=1 -> sr_frame=12'hC0E.
//  4. Drive tx_valid with 0x3C during SHIFT -> not accepted, tx_ready=0, frame unchanged.
//     Accepted on the cycle after done.
//  5. Pull reset low after the 5th sr_en -> state IDLE at once, no done, no further
//     sr_en, line model returns to 1.
//  6. Send 0x00 then 0xFF back-to-back with tx_valid held -> frames 12'hC00 and 12'hDFE.
//     Second sr_load exactly 2 cycles after the first done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, transmit FSM states, frame builder.
package uart_pkg;

  localparam int FRAME_BITS = 12;
  localparam int STOP_BITS  = 2;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, HOLD} tx_state_t;

  // Frame layout, LSB goes out first: start(0), data[7:0], parity, stop bits.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data,
                                                        input logic       parity_odd);
    return {{STOP_BITS{1'b1}}, (^data) ^ parity_odd, data, 1'b0};
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte handshake between the core and the transmit framer.
interface uart_tx_framer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timebase: counts 0..CLK_DIV-1 while running, tick on the last count.
// Shared by the transmit and receive paths.
module uart_baud_gen #(
  parameter int CLK_DIV = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == TERM);

  // Next count: clear wins, otherwise advance and wrap on the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)    cnt_d = '0;
    else if (run) cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a byte, builds the 12-bit frame and paces the
// external shift register (load once, then one shift per bit period).
module uart_tx_framer import uart_pkg::*; #(
  parameter int CLK_DIV    = 434,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_tx_framer_if.slave       tx,
  output logic                  sr_load,
  output logic                  sr_en,
  output logic [FRAME_BITS-1:0] sr_frame,
  output logic                  sr_fill,
  output logic                  busy,
  output logic                  done
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  tx_state_t             state_q;
  logic [3:0]            bit_cnt_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  ready_q, load_q, en_q, done_q;
  logic                  tick;

  // The counter sits at zero in IDLE so the LOAD cycle is count 0 of the
  // first bit period; this puts shift k exactly k periods after the load.
  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == IDLE),
    .run   (state_q != IDLE),
    .tick  (tick)
  );

  // Framer FSM with registered handshake and shift-register controls.
  // ready rises one cycle after returning to IDLE, so done and ready never overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      ready_q   <= 1'b1;
      load_q    <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      load_q <= 1'b0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && tx.tx_valid) begin
            frame_q <= build_frame(tx.tx_data, PARITY_ODD);
            ready_q <= 1'b0;
            load_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          bit_cnt_q <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            en_q      <= 1'b1;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) state_q <= HOLD;
          end
        end
        HOLD: begin
          // One more full period so the last stop bit keeps its width.
          if (tick) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx.tx_ready = ready_q;
  assign busy        = ~ready_q;
  assign sr_load     = load_q;
  assign sr_en       = en_q;
  assign sr_frame    = frame_q;
  assign sr_fill     = 1'b1;
  assign done        = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: directed cases plus random bytes, checked every
// falling edge against a transaction-level timing model and a line model.
module tb_uart_tx_framer;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_framer_if ev();
  uart_tx_framer_if od();

  logic        sr_load, sr_en, sr_fill, busy, done;
  logic [11:0] sr_frame;
  logic        o_load, o_en, o_fill, o_busy, o_done;
  logic [11:0] o_frame;

  assign od.tx_data  = ev.tx_data;
  assign od.tx_valid = ev.tx_valid;

  uart_tx_framer #(.CLK_DIV(D), .PARITY_ODD(1'b0)) u_dut (
    .clk(clk), .reset(reset), .tx(ev.slave),
    .sr_load(sr_load), .sr_en(sr_en), .sr_frame(sr_frame), .sr_fill(sr_fill),
    .busy(busy), .done(done)
  );

  uart_tx_framer #(.CLK_DIV(D), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .reset(reset), .tx(od.slave),
    .sr_load(o_load), .sr_en(o_en), .sr_frame(o_frame), .sr_fill(o_fill),
    .busy(o_busy), .done(o_done)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Frame from the framing rule: start 0, data LSB first, parity, two stop 1s.
  function automatic logic [11:0] ref_frame(input logic [7:0] b, input bit odd);
    bit par;
    par = (($countones(b) % 2) == 1) ^ odd;
    return 12'hC00 | (12'(par) << 9) | (12'(b) << 1);
  endfunction

  // Reference model state: one transaction in flight, described by its load cycle.
  int          load_at    = -1;
  int          ready_from = 0;
  logic [11:0] m_frame    = '0;
  logic [11:0] m_frame_o  = '0;
  logic [11:0] pend, pend_o;
  bit          acc_flag   = 1'b0;
  // Line model: shift register sampling load/en on the falling edge, plus output bit.
  logic [11:0] ln_sr = '1;
  logic        ln    = 1'b1;
  logic        ln_log[$];
  int          last_load = -1;
  int          last_done = -1;

  always @(negedge clk) begin : scoreboard
    int   n, k, ec;
    logic exp_en;
    n = cyc;
    if (!reset) begin
      load_at = -1; ready_from = 0; m_frame = '0; m_frame_o = '0;
      ln_sr = '1; ln = 1'b1;
    end else begin
      if (sr_load) begin ln_sr = sr_frame; ln_log.push_back(ln); last_load = n; end
      if (sr_en) begin
        ln = ln_sr[0];
        ln_sr = {1'b1, ln_sr[11:1]};
        ln_log.push_back(ln);
      end
      if (done) last_done = n;
    end
    if (load_at >= 0 && n == load_at) begin m_frame = pend; m_frame_o = pend_o; end
    ec = 0; exp_en = 1'b0;
    if (load_at >= 0 && n >= load_at) begin
      k      = (n - load_at) / D;
      ec     = (k > 12) ? 12 : k;
      exp_en = ((n - load_at) % D == 0) && k >= 1 && k <= 12;
    end
    chk("sr_load",      sr_load,     load_at >= 0 && n == load_at);
    chk("sr_en",        sr_en,       exp_en);
    chk("done",         done,        load_at >= 0 && n == load_at + 13*D);
    chk("tx_ready",     ev.tx_ready, n >= ready_from);
    chk("busy",         busy,        n < ready_from);
    chk("sr_fill",      sr_fill,     1);
    chk("sr_frame",     sr_frame,    m_frame);
    chk("tx_ready_odd", od.tx_ready, n >= ready_from);
    chk("sr_frame_odd", o_frame,     m_frame_o);
    chk("line",         ln,          (ec == 0) ? 1'b1 : m_frame[ec-1]);
    acc_flag = 1'b0;
    if (reset && ev.tx_valid && n >= ready_from) begin
      acc_flag   = 1'b1;
      pend       = ref_frame(ev.tx_data, 1'b0);
      pend_o     = ref_frame(ev.tx_data, 1'b1);
      load_at    = n + 1;
      ready_from = n + 2 + 13*D;
    end
  end

  task automatic tick_n(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  // Returns #1 after the accepting edge (the LOAD cycle); bounded wait.
  task automatic wait_accept(output int waited);
    bit got;
    got = 1'b0; waited = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(posedge clk);
      waited++;
      got = acc_flag;
    end
    if (!got) chk("accept_timeout", 0, 1);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit hold);
    int w;
    ev.tx_valid = 1'b1;
    ev.tx_data  = b;
    wait_accept(w);
    if (!hold) begin ev.tx_valid = 1'b0; ev.tx_data = 8'($urandom); end
  endtask

  bit exp_l [13] = '{1,0,1,0,1,0,0,1,0,1,0,1,1};

  initial begin
    int w, saved_done;
    bit hold;
    reset = 1'b0; ev.tx_valid = 1'b1; ev.tx_data = 8'h5A;

    // Reset held with a byte offered; accepted on the first edge after release.
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    wait_accept(w);
    chk("t1_first_edge", w, 1);
    ev.tx_valid = 1'b0;
    tick_n(13*D + 4);

    // 0xA5: frame value, latency of done, serial line sequence.
    ln_log.delete();
    send(8'hA5, 1'b0);
    tick_n(13*D + 4);
    chk("t2_frame", sr_frame, 12'hD4A);
    chk("t2_done_lat", last_done - last_load, 13*D);
    chk("t2_line_len", ln_log.size(), 13);
    for (int i = 0; i < 13 && i < ln_log.size(); i++) chk("t2_line", ln_log[i], exp_l[i]);

    // 0x07: even and odd parity.
    send(8'h07, 1'b0);
    tick_n(2);
    chk("t3_even", sr_frame, 12'hE0E);
    chk("t3_odd",  o_frame,  12'hC0E);

    // Offer 0x3C mid-frame: held off until the cycle after done.
    tick_n(6);
    ev.tx_valid = 1'b1; ev.tx_data = 8'h3C;
    tick_n(1);
    chk("t4_busy_frame", sr_frame, 12'hE0E);
    wait_accept(w);
    chk("t4_gap", cyc - last_done, 2);
    ev.tx_valid = 1'b0;
    tick_n(2);
    chk("t4_frame", sr_frame, 12'hC78);
    tick_n(13*D + 4);

    // Reset after the 5th shift: abort, no done, line back to idle.
    send(8'h96, 1'b0);
    saved_done = last_done;
    tick_n(5*D + 1);
    reset = 1'b0;
    #1;
    chk("t5_ready", ev.tx_ready, 1);
    chk("t5_frame", sr_frame, 0);
    tick_n(2);
    reset = 1'b1;
    tick_n(13*D + 4);
    chk("t5_no_done", last_done, saved_done);
    chk("t5_line", ln, 1);

    // Back-to-back with valid held.
    ev.tx_valid = 1'b1; ev.tx_data = 8'h00;
    wait_accept(w);
    chk("t6_f1", sr_frame, 12'hC00);
    ev.tx_data = 8'hFF;
    wait_accept(w);
    chk("t6_f2", sr_frame, 12'hDFE);
    chk("t6_gap", cyc - last_done, 2);
    ev.tx_valid = 1'b0;
    tick_n(13*D + 4);

    // Random bytes, gaps, held valid and occasional mid-frame reset.
    for (int i = 0; i < 40; i++) begin
      if (!ev.tx_valid) ev.tx_data = 8'($urandom);
      tick_n($urandom_range(0, 3));
      hold = 1'($urandom_range(0, 1));
      send(8'($urandom), hold);
      if ($urandom_range(0, 5) == 0) begin
        tick_n($urandom_range(1, 13*D));
        reset = 1'b0;
        tick_n($urandom_range(1, 3));
        reset = 1'b1;
      end
    end
    ev.tx_valid = 1'b0;
    tick_n(13*D + 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
